bus_cmd_master: RTL
===================

BUS_CMD_MASTER -- requirements
Module: bus_cmd_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: max WAIT_RD cycles before a read is aborted; legal range 1..255.
REQ-002 Port i_Bus_Clk  in  1: sole clock; all logic on rising edge.
REQ-003 Port i_Bus_Rst_L  in  1: reset, asynchronous assert, active-low.
REQ-004 Port i_Cmd_Valid  in  1: command request.
REQ-005 Port i_Cmd_Wr_Rd_n  in  1: 1 = write, 0 = read.
REQ-006 Port i_Cmd_Addr8  in  4: byte address of 16-bit word.
REQ-007 Port i_Cmd_Wr_Data  in  16: write data.
REQ-008 Port o_Cmd_Ready  out  1: master can accept a command this cycle.
REQ-009 Port o_Bus_CS  out  1: bus chip select, one-cycle pulse per command.
REQ-010 Port o_Bus_Wr_Rd_n  out  1: bus direction.
REQ-011 Port o_Bus_Addr8  out  4: bus address.
REQ-012 Port o_Bus_Wr_Data  out  16: bus write data.
REQ-013 Port i_Bus_Rd_Data  in  16: responder read data.
REQ-014 Port i_Bus_Rd_DV  in  1: responder read-data-valid pulse.
REQ-015 Port o_Rsp_DV  out  1: one-cycle completion pulse.
REQ-016 Port o_Rsp_Rd_Data  out  16: read result, valid with o_Rsp_DV.
REQ-017 Port o_Rsp_Timeout  out  1: read aborted, valid with o_Rsp_DV.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT_RD; o_Cmd_Ready = 1 only in IDLE.
REQ-019 Accept: i_Cmd_Valid & o_Cmd_Ready at edge N -> command fields registered to o_Bus_* and state -> ISSUE; fields need not be held after acceptance.
REQ-020 ISSUE (cycle N+1): o_Bus_CS = 1 for exactly this one cycle; write -> IDLE, read -> WAIT_RD with timeout counter cleared to 0.
REQ-021 Write completion: o_Rsp_DV = 1, o_Rsp_Timeout = 0 in cycle N+2 (first IDLE cycle); o_Rsp_Rd_Data unchanged.
REQ-022 WAIT_RD: i_Bus_Rd_DV sampled high -> i_Bus_Rd_Data captured to o_Rsp_Rd_Data, o_Rsp_DV = 1, o_Rsp_Timeout = 0 next cycle, state -> IDLE; nominal read response at N+3.
REQ-023 WAIT_RD without i_Bus_Rd_DV: counter increments each cycle; at TIMEOUT_CYCLES cycles -> o_Rsp_DV = 1, o_Rsp_Timeout = 1, o_Rsp_Rd_Data = 0x0000 next cycle, state -> IDLE.
REQ-024 i_Bus_Rd_DV in the same cycle the counter reaches its limit SHALL win: normal data response, no timeout.
REQ-025 i_Bus_Rd_DV outside WAIT_RD (stray or late) SHALL be ignored; no response generated.
REQ-026 Back-to-back: a command accepted in the same cycle o_Rsp_DV is high SHALL be legal; CS pulses then spaced 2 cycles (write) or 3 cycles (read, DV at CS+1).
REQ-027 o_Bus_Wr_Rd_n, o_Bus_Addr8, o_Bus_Wr_Data SHALL hold last-issued values until next acceptance.
REQ-028 o_Rsp_DV SHALL be high for exactly one cycle per accepted command; never more than one response per command.
REQ-029 Counter width SHALL be 8 bits; no wrap possible within legal range.

Reset
REQ-030 On i_Bus_Rst_L = 0, immediately: state IDLE, o_Bus_CS 0, o_Bus_Wr_Rd_n 0, o_Bus_Addr8 0x0, o_Bus_Wr_Data 0x0000, o_Rsp_DV 0, o_Rsp_Rd_Data 0x0000, o_Rsp_Timeout 0, counter 0.
REQ-031 Reset mid-operation SHALL abandon the in-flight command with no response; o_Cmd_Ready = 1 the first cycle after release.

Verification
REQ-032 Write addr 0x4 data 0xBEEF -> single CS at N+1 with Wr_Rd_n=1, Addr8=0x4, Wr_Data=0xBEEF; Rsp_DV at N+2, Timeout 0.
REQ-033 Read addr 0xA, responder returns 0x1234 at CS+1 -> Rsp_DV at N+3, Rsp_Rd_Data 0x1234, Timeout 0.
REQ-034 Read with no responder, TIMEOUT_CYCLES=15 -> Rsp_DV with Timeout 1, data 0x0000, 15 cycles after WAIT_RD entry; subsequent late DV ignored.
REQ-035 Valid held high for 8 alternating write/read commands to addrs 0x0..0xE -> 8 CS pulses, 8 Rsp_DV pulses, ready low during each command, correct data order.
REQ-036 Reset asserted during WAIT_RD -> outputs at reset values asynchronously, no Rsp_DV; next read completes normally.
REQ-037 DV arriving exactly at timeout limit (TIMEOUT_CYCLES=3) -> data response, Timeout 0.

Source files
------------

// File: rtl/bus_cmd_master.sv
// Single-outstanding command master for a simple CS-strobed bus.
// Issues one write or read per accepted command and returns a single completion pulse.
`timescale 1ns/1ps

module bus_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        i_Bus_Clk,
  input  logic        i_Bus_Rst_L,
  input  logic        i_Cmd_Valid,
  input  logic        i_Cmd_Wr_Rd_n,
  input  logic [3:0]  i_Cmd_Addr8,
  input  logic [15:0] i_Cmd_Wr_Data,
  output logic        o_Cmd_Ready,
  output logic        o_Bus_CS,
  output logic        o_Bus_Wr_Rd_n,
  output logic [3:0]  o_Bus_Addr8,
  output logic [15:0] o_Bus_Wr_Data,
  input  logic [15:0] i_Bus_Rd_Data,
  input  logic        i_Bus_Rd_DV,
  output logic        o_Rsp_DV,
  output logic [15:0] o_Rsp_Rd_Data,
  output logic        o_Rsp_Timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_e;

  // Counter value seen during the last permitted WAIT_RD cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cs_q, cs_d;
  logic        bus_wr_rd_n_q, bus_wr_rd_n_d;
  logic [3:0]  bus_addr8_q, bus_addr8_d;
  logic [15:0] bus_wr_data_q, bus_wr_data_d;
  logic        rsp_dv_q, rsp_dv_d;
  logic [15:0] rsp_rd_data_q, rsp_rd_data_d;
  logic        rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    cs_d          = 1'b0;
    bus_wr_rd_n_d = bus_wr_rd_n_q;
    bus_addr8_d   = bus_addr8_q;
    bus_wr_data_d = bus_wr_data_q;
    rsp_dv_d      = 1'b0;
    rsp_rd_data_d = rsp_rd_data_q;
    rsp_timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_Cmd_Valid) begin
          bus_wr_rd_n_d = i_Cmd_Wr_Rd_n;
          bus_addr8_d   = i_Cmd_Addr8;
          bus_wr_data_d = i_Cmd_Wr_Data;
          cs_d          = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (bus_wr_rd_n_q) begin
          rsp_dv_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d   = 8'd0;
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        // Responder data beats the timeout when both land on the last cycle.
        if (i_Bus_Rd_DV) begin
          rsp_dv_d      = 1'b1;
          rsp_rd_data_d = i_Bus_Rd_Data;
          state_d       = IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          rsp_dv_d      = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rd_data_d = 16'h0000;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      cs_q          <= 1'b0;
      bus_wr_rd_n_q <= 1'b0;
      bus_addr8_q   <= 4'h0;
      bus_wr_data_q <= 16'h0000;
      rsp_dv_q      <= 1'b0;
      rsp_rd_data_q <= 16'h0000;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cs_q          <= cs_d;
      bus_wr_rd_n_q <= bus_wr_rd_n_d;
      bus_addr8_q   <= bus_addr8_d;
      bus_wr_data_q <= bus_wr_data_d;
      rsp_dv_q      <= rsp_dv_d;
      rsp_rd_data_q <= rsp_rd_data_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign o_Cmd_Ready   = (state_q == IDLE);
  assign o_Bus_CS      = cs_q;
  assign o_Bus_Wr_Rd_n = bus_wr_rd_n_q;
  assign o_Bus_Addr8   = bus_addr8_q;
  assign o_Bus_Wr_Data = bus_wr_data_q;
  assign o_Rsp_DV      = rsp_dv_q;
  assign o_Rsp_Rd_Data = rsp_rd_data_q;
  assign o_Rsp_Timeout = rsp_timeout_q;

endmodule
